// File: rtl/sram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_responder_pkg
//  Purpose  : Shared constants and helpers for the SRAM-port responder:
//             MMIO register offsets, CTRL bit indices, the default MMIO
//             window base and the byte-lane merge function.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package sram_responder_pkg;

   localparam logic [31:0] MMIO_BASE_DEF = 32'hBFAF_0000;

   localparam logic [15:0] OFF_TIMER   = 16'h0000;
   localparam logic [15:0] OFF_COMPARE = 16'h0004;
   localparam logic [15:0] OFF_CTRL    = 16'h0008;
   localparam logic [15:0] OFF_STATUS  = 16'h000C;

   localparam int CTRL_TMR_EN = 0;
   localparam int CTRL_IRQ_EN = 1;

   // Lane i of the result comes from new_w when we[i] is set, else from old_w.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  we);
      logic [31:0] merged;
      merged = old_w;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) merged[8*i +: 8] = new_w[8*i +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_tmr_regs.sv
`default_nettype none
// ============================================================================
//  Module   : sram_tmr_regs
//  Purpose  : MMIO timer block: TIMER, COMPARE, CTRL and the pending flag,
//             plus the registered interrupt output.
//  Ports    : clk, resetn      - clock, async active-low reset
//             wr_i             - bus write to the MMIO window this cycle
//             we_i             - byte write enables
//             off_i            - register offset inside the window
//             wdata_i          - write data
//             rdata_o          - combinational read data for off_i
//             irq_o            - timer interrupt (pend & irq_en), from a flop
//  Revision : 1.0  initial release
// ============================================================================
module sram_tmr_regs
   import sram_responder_pkg::*;
#(
   parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wr_i,
   input  logic [3:0]  we_i,
   input  logic [15:0] off_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   logic [31:0] timer_q, timer_d;
   logic [31:0] compare_q, compare_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        pend_q, pend_d;
   logic        irq_q, irq_d;
   logic [31:0] timer_inc;
   logic        match, w1c;

   always_comb begin
      timer_inc = timer_q + {31'd0, ctrl_q[CTRL_TMR_EN]};
      timer_d   = timer_inc;
      compare_d = compare_q;
      ctrl_d    = ctrl_q;
      w1c       = 1'b0;
      if (wr_i) begin
         case (off_i)
            // Unwritten lanes keep counting; written lanes take the bus value.
            OFF_TIMER:   timer_d   = byte_merge(timer_inc, wdata_i, we_i);
            OFF_COMPARE: compare_d = byte_merge(compare_q, wdata_i, we_i);
            OFF_CTRL:    if (we_i[0]) ctrl_d = wdata_i[1:0];
            OFF_STATUS:  w1c = we_i[0] & wdata_i[0];
            default:     ;
         endcase
      end
      // Compare uses pre-edge values; a same-cycle set beats the clear.
      match  = ctrl_q[CTRL_TMR_EN] && (timer_q == compare_q);
      pend_d = match | (pend_q & ~w1c);
      irq_d  = pend_d & ctrl_d[CTRL_IRQ_EN];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_q   <= '0;
         compare_q <= CMP_RST;
         ctrl_q    <= '0;
         pend_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         compare_q <= compare_d;
         ctrl_q    <= ctrl_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      case (off_i)
         OFF_TIMER:   rdata_o = timer_q;
         OFF_COMPARE: rdata_o = compare_q;
         OFF_CTRL:    rdata_o = {30'd0, ctrl_q};
         OFF_STATUS:  rdata_o = {31'd0, pend_q};
         default:     rdata_o = '0;
      endcase
   end

   assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_responder
//  Purpose  : Target side of a byte-enabled SRAM port. Decodes each request
//             to either a word-addressed RAM or the MMIO timer block and
//             returns read data one cycle later.
//  Ports    : clk, resetn      - clock, async active-low reset
//             sram_en          - request valid
//             sram_we          - byte write enables (0 = read)
//             sram_addr        - byte address
//             sram_wdata       - write data
//             sram_rdata       - registered read data
//             int_out          - interrupt vector, bit0 = timer IRQ
//  Revision : 1.0  initial release
// ============================================================================
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
   parameter logic [31:0] CMP_RST   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sram_en,
   input  logic [3:0]  sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic [7:0]  int_out
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] word_idx;
   logic              mmio_hit, is_read, is_write;
   logic [31:0]       mmio_rdata;
   logic              irq;

   // Upper address bits above the RAM index simply alias.
   assign mmio_hit = (sram_addr[31:16] == MMIO_BASE[31:16]);
   assign word_idx = sram_addr[ADDR_W+1:2];
   assign is_read  = sram_en && (sram_we == 4'd0);
   assign is_write = sram_en && (sram_we != 4'd0);

   sram_tmr_regs #(
      .CMP_RST (CMP_RST)
   ) u_tmr_regs (
      .clk     (clk),
      .resetn  (resetn),
      .wr_i    (is_write && mmio_hit),
      .we_i    (sram_we),
      .off_i   (sram_addr[15:0]),
      .wdata_i (sram_wdata),
      .rdata_o (mmio_rdata),
      .irq_o   (irq)
   );

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (is_write && !mmio_hit) begin
         mem_q[word_idx] <= byte_merge(mem_q[word_idx], sram_wdata, sram_we);
      end
   end

   // Read data holds on write and idle cycles.
   always_comb begin
      rdata_d = rdata_q;
      if (is_read) rdata_d = mmio_hit ? mmio_rdata : mem_q[word_idx];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rdata_q <= '0;
      else         rdata_q <= rdata_d;
   end

   assign sram_rdata = rdata_q;
   assign int_out    = {7'd0, irq};

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_responder
//  Purpose  : Self-checking bench for sram_responder. The driver queues the
//             expected value of every read; a monitor pops and compares one
//             entry for each read the DUT completes.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_responder;

   localparam logic [31:0] M = 32'hBFAF_0000;

   logic        clk;
   logic        resetn;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [7:0]  int_out;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   logic rd_flag;

   sram_responder dut (
      .clk        (clk),
      .resetn     (resetn),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .int_out    (int_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A read accepted at a rising edge (outside reset) has data by the next falling edge.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) rd_flag <= 1'b0;
      else         rd_flag <= sram_en && (sram_we == 4'd0);
   end

   always @(negedge clk) begin
      if (rd_flag) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_read: got %h expected no read", sram_rdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            check(e.name, sram_rdata, e.exp);
         end
      end
   end

   task automatic bus(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
      sram_en    = 1'b1;
      sram_we    = we;
      sram_addr  = addr;
      sram_wdata = wdata;
      @(negedge clk);
      sram_en    = 1'b0;
      sram_we    = 4'd0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
      bus(we, addr, data);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.exp  = exp;
      q.push_back(e);
      bus(4'd0, addr, 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn     = 1'b0;
      sram_en    = 1'b0;
      sram_we    = 4'd0;
      sram_addr  = 32'd0;
      sram_wdata = 32'd0;
      idle(3);
      check("reset_rdata", sram_rdata, 32'd0);
      check("reset_int", {24'd0, int_out}, 32'd0);
      resetn = 1'b1;
      idle(1);

      rd(M + 32'h4, 32'hFFFF_FFFF, "reset_compare");
      rd(M + 32'h8, 32'd0, "reset_ctrl");

      // RAM full write, read, hold
      wr(32'h10, 32'hDEAD_BEEF, 4'hF);
      rd(32'h10, 32'hDEAD_BEEF, "ram_full");
      idle(2);
      check("hold_idle", sram_rdata, 32'hDEAD_BEEF);
      wr(32'h20, 32'h0BAD_F00D, 4'hF);
      check("hold_write", sram_rdata, 32'hDEAD_BEEF);

      // Byte lane, aliasing, back-to-back
      wr(32'h10, 32'h0000_5500, 4'b0010);
      rd(32'h10, 32'hDEAD_55EF, "ram_lane1");
      wr(32'h4, 32'h1234_5678, 4'hF);
      rd(32'h4004, 32'h1234_5678, "ram_alias");
      rd(32'h20, 32'h0BAD_F00D, "b2b_a");
      rd(32'h10, 32'hDEAD_55EF, "b2b_b");

      // Unmapped MMIO offset
      wr(M + 32'h10, 32'hFFFF_FFFF, 4'hF);
      rd(M + 32'h10, 32'd0, "mmio_unmapped");

      // Timer compare match and interrupt
      wr(M + 32'h4, 32'd5, 4'hF);
      wr(M + 32'h0, 32'd0, 4'hF);
      wr(M + 32'h8, 32'd3, 4'hF);         // TIMER is 0 now, counting from here
      idle(5);                            // TIMER = 5, match not yet latched
      check("irq_before_match", {24'd0, int_out}, 32'd0);
      idle(1);                            // pend set, TIMER = 6
      check("irq_on_match", {24'd0, int_out}, 32'h1);
      rd(M + 32'h0, 32'd6, "timer_counting");
      wr(M + 32'hC, 32'd1, 4'b0001);      // W1C
      check("irq_after_w1c", {24'd0, int_out}, 32'd0);
      rd(M + 32'hC, 32'd0, "status_cleared");

      // Re-arm, then mask with irq_en=0
      wr(M + 32'h0, 32'h20, 4'hF);
      wr(M + 32'h4, 32'h21, 4'hF);        // TIMER reaches 0x21 here
      idle(1);
      check("irq_rearm", {24'd0, int_out}, 32'h1);
      wr(M + 32'h8, 32'd1, 4'hF);
      check("irq_masked", {24'd0, int_out}, 32'd0);
      rd(M + 32'hC, 32'd1, "status_kept");
      rd(M + 32'h8, 32'd1, "ctrl_rb");

      // W1C coincident with a match: set wins
      wr(M + 32'hC, 32'd1, 4'b0001);
      rd(M + 32'hC, 32'd0, "status_clr2");
      wr(M + 32'h0, 32'h40, 4'hF);
      wr(M + 32'h4, 32'h41, 4'hF);        // TIMER = 0x41 = COMPARE now
      wr(M + 32'hC, 32'd1, 4'b0001);
      rd(M + 32'hC, 32'd1, "set_beats_w1c");

      // Wrap, then partial TIMER write
      wr(M + 32'h0, 32'hFFFF_FFFF, 4'hF);
      idle(1);
      rd(M + 32'h0, 32'd0, "timer_wrap");  // TIMER becomes 1 after this edge
      wr(M + 32'h0, 32'h0000_AB00, 4'b0010); // pre 1 -> incremented 2, lane1 = AB
      rd(M + 32'h0, 32'h0000_AB02, "timer_partial");

      // Reset during a read request
      wr(M + 32'h8, 32'd3, 4'hF);
      check("irq_pre_reset", {24'd0, int_out}, 32'h1);
      check("rdata_pre_reset", sram_rdata, 32'h0000_AB02);
      sram_en   = 1'b1;
      sram_we   = 4'd0;
      sram_addr = 32'h10;
      #2 resetn = 1'b0;
      @(posedge clk);
      #1;
      check("rst_rdata", sram_rdata, 32'd0);
      check("rst_int", {24'd0, int_out}, 32'd0);
      @(negedge clk);
      sram_en = 1'b0;
      resetn  = 1'b1;
      rd(M + 32'h4, 32'hFFFF_FFFF, "rst_compare");
      rd(M + 32'h0, 32'd0, "rst_timer");
      rd(M + 32'hC, 32'd0, "rst_status");
      rd(32'h10, 32'hDEAD_55EF, "ram_kept");
      idle(2);

      check("queue_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
